// File: rtl/aidc_lite_pkg.sv
// Shared constants and types for the AIDC-Lite code drain stage: word and
// block sizes, bank and drain-FSM state encodings, header field layout and a
// helper that builds the optional block header word.
package aidc_lite_pkg;

  localparam int AIDC_LITE_WORD_W    = 64;
  localparam int AIDC_LITE_BLK_WORDS = 8;

  // Header word layout: {zeros, seq[7:0], cnt[3:0]}
  localparam int HDR_CNT_LSB = 0;
  localparam int HDR_CNT_W   = 4;
  localparam int HDR_SEQ_LSB = 4;
  localparam int HDR_SEQ_W   = 8;

  typedef enum logic [1:0] {
    BANK_FREE   = 2'd0,
    BANK_FILL   = 2'd1,
    BANK_CLOSED = 2'd2,
    BANK_DRAIN  = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    DRN_IDLE = 2'd0,
    DRN_HDR  = 2'd1,
    DRN_DATA = 2'd2
  } drain_state_e;

  function automatic logic [AIDC_LITE_WORD_W-1:0] make_hdr(
    input logic [HDR_SEQ_W-1:0] seq,
    input logic [HDR_CNT_W-1:0] cnt
  );
    logic [AIDC_LITE_WORD_W-1:0] h;
    h = '0;
    h[HDR_CNT_LSB +: HDR_CNT_W] = cnt;
    h[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    return h;
  endfunction

endpackage

// File: rtl/aidc_lite_drain_bank.sv
// One ping-pong bank: DEPTH x DATA_W word store, its lifecycle state and the
// high-water mark (hi) of the block being filled. When the bank leaves FILL,
// hi (including a write in that same cycle) is frozen into cnt.
module aidc_lite_drain_bank
  import aidc_lite_pkg::*;
#(
  parameter int DATA_W     = AIDC_LITE_WORD_W,
  parameter int DEPTH      = AIDC_LITE_BLK_WORDS,
  parameter bit RESET_FILL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       cmd_fill,
  input  logic                       cmd_close,
  input  logic                       cmd_drain,
  input  logic                       cmd_free,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     blk_cnt,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  bank_state_e       st;
  logic [CW-1:0]     hi;
  logic [CW-1:0]     hi_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     wr_top;

  // High-water mark including a write landing this cycle.
  always_comb begin
    wr_top = CW'(wr_addr) + CW'(1);
    hi_nxt = hi;
    if (wr_en && (wr_top > hi)) hi_nxt = wr_top;
  end

  // Word store; contents are only meaningful below hi/cnt, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Bank lifecycle and block size tracking; drain wins over close so a bank
  // closing straight into the drain stage skips CLOSED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= RESET_FILL ? BANK_FILL : BANK_FREE;
      hi  <= '0;
      cnt <= '0;
    end else begin
      if (cmd_drain)      st <= BANK_DRAIN;
      else if (cmd_close) st <= BANK_CLOSED;
      else if (cmd_fill)  st <= BANK_FILL;
      else if (cmd_free)  st <= BANK_FREE;

      if ((cmd_drain || cmd_close) && (st == BANK_FILL)) begin
        cnt <= hi_nxt;
        hi  <= '0;
      end else if (wr_en) begin
        hi <= hi_nxt;
      end
    end
  end

  // Read path bypasses a same-cycle write so a block can start draining on
  // the edge its last word arrives.
  always_comb begin
    state   = st;
    blk_cnt = (st == BANK_FILL) ? hi_nxt : cnt;
    rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/aidc_lite_code_drain.sv
// AIDC-Lite code drain: captures concatenator words into two ping-pong banks,
// closes a bank on the rising edge of done_i and drains closed banks, oldest
// first, as a valid/ready word stream with last and word-count sideband.
// Optional feature macro: AIDC_LITE_DRAIN_HDR_EN prefixes each block with a
// header word {52'd0, seq[7:0], cnt[3:0]}.
//
// Output handshake: a word transfers on a rising edge where m_valid_o and
// m_ready_i are both 1. Once m_valid_o is raised, m_valid_o, m_data_o,
// m_last_o and m_cnt_o hold until that transfer; m_valid_o never drops
// without a transfer. m_data_o/m_last_o hold their value while m_valid_o=0.
module aidc_lite_code_drain
  import aidc_lite_pkg::*;
#(
  parameter int DATA_W = AIDC_LITE_WORD_W,
  parameter int DEPTH  = AIDC_LITE_BLK_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     done_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [DATA_W-1:0]        m_data_o,
  output logic                     m_last_o,
  output logic [$clog2(DEPTH):0]   m_cnt_o,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef AIDC_LITE_DRAIN_HDR_EN
  localparam drain_state_e FIRST_ST = DRN_HDR;
`else
  localparam drain_state_e FIRST_ST = DRN_DATA;
`endif

  logic [1:0]        bank_st  [2];
  logic [CW-1:0]     bank_cnt [2];
  logic [DATA_W-1:0] bank_rd  [2];
  logic [1:0]        wr_en;
  logic [1:0]        cmd_fill;
  logic [1:0]        cmd_close;
  logic [1:0]        cmd_drain;
  logic [1:0]        cmd_free;
  logic [AW-1:0]     rd_addr;

  logic              done_d;
  logic              close_evt;
  logic              fill_valid;
  logic              fill_sel;
  logic              wr_ok;
  logic              close_ok;
  logic              ovr_set;

  drain_state_e      drn_st;
  drain_state_e      drn_nxt;
  logic              oldest;
  logic [AW-1:0]     rd_ptr;
  logic              beat;
  logic              blk_done;
  logic              nxt_bank;
  logic              nxt_ready;
  logic              start;
  logic [CW-1:0]     start_cnt;
  logic              hdr_beat;
`ifdef AIDC_LITE_DRAIN_HDR_EN
  logic [HDR_SEQ_W-1:0] seq;
`endif

  aidc_lite_drain_bank #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .RESET_FILL (1'b1)
  ) u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en[0]),
    .wr_addr   (addr_i),
    .wr_data   (data_i),
    .cmd_fill  (cmd_fill[0]),
    .cmd_close (cmd_close[0]),
    .cmd_drain (cmd_drain[0]),
    .cmd_free  (cmd_free[0]),
    .rd_addr   (rd_addr),
    .state     (bank_st[0]),
    .blk_cnt   (bank_cnt[0]),
    .rd_data   (bank_rd[0])
  );

  aidc_lite_drain_bank #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .RESET_FILL (1'b0)
  ) u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en[1]),
    .wr_addr   (addr_i),
    .wr_data   (data_i),
    .cmd_fill  (cmd_fill[1]),
    .cmd_close (cmd_close[1]),
    .cmd_drain (cmd_drain[1]),
    .cmd_free  (cmd_free[1]),
    .rd_addr   (rd_addr),
    .state     (bank_st[1]),
    .blk_cnt   (bank_cnt[1]),
    .rd_data   (bank_rd[1])
  );

  // done_d resets to 1 so a concatenator coming out of reset with done high
  // does not produce a spurious close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_d <= 1'b1;
    else     done_d <= done_i;
  end

  // Write steering, close qualification and overrun detection. A missing
  // fill bank is only an error once a write or close actually arrives.
  always_comb begin
    close_evt  = done_i & ~done_d;
    fill_valid = (bank_st[0] == BANK_FILL) | (bank_st[1] == BANK_FILL);
    fill_sel   = (bank_st[1] == BANK_FILL);
    wr_ok      = valid_i & fill_valid;
    close_ok   = close_evt & fill_valid & (bank_cnt[fill_sel] != '0);
    ovr_set    = (valid_i | close_evt) & ~fill_valid;
  end

  // Drain sequencing terms: the next block to drain is always the bank after
  // the one completing, and it may be closing on this very edge.
  always_comb begin
    beat      = m_valid_o & m_ready_i;
    blk_done  = (drn_st == DRN_DATA) & beat & m_last_o;
    nxt_bank  = oldest ^ blk_done;
    nxt_ready = (bank_st[nxt_bank] == BANK_CLOSED) |
                (close_ok & (fill_sel == nxt_bank));
    start     = ((drn_st == DRN_IDLE) | blk_done) & nxt_ready;
    start_cnt = bank_cnt[nxt_bank];
`ifdef AIDC_LITE_DRAIN_HDR_EN
    hdr_beat  = (drn_st == DRN_HDR) & beat;
`else
    hdr_beat  = 1'b0;
`endif
    rd_addr   = ((drn_st == DRN_DATA) && !m_last_o) ? (rd_ptr + AW'(1)) : '0;
  end

  // Bank commands. A bank freed while no other bank is filling (or while the
  // fill bank closes) goes straight back to FILL.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      wr_en[b]     = wr_ok & (fill_sel == b[0]);
      cmd_drain[b] = start & (nxt_bank == b[0]);
      cmd_close[b] = close_ok & (fill_sel == b[0]);
      cmd_free[b]  = blk_done & (oldest == b[0]);
      cmd_fill[b]  = (close_ok & (fill_sel != b[0]) & (bank_st[b] == BANK_FREE)) |
                     (cmd_free[b] & (~fill_valid | close_ok));
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drn_st <= DRN_IDLE;
    else     drn_st <= drn_nxt;
  end

  // Drain FSM next-state.
  always_comb begin
    drn_nxt = drn_st;
    case (drn_st)
      DRN_IDLE: if (start) drn_nxt = FIRST_ST;
`ifdef AIDC_LITE_DRAIN_HDR_EN
      DRN_HDR:  if (beat) drn_nxt = DRN_DATA;
`endif
      DRN_DATA: if (blk_done) drn_nxt = start ? FIRST_ST : DRN_IDLE;
      default:  drn_nxt = DRN_IDLE;
    endcase
  end

  // Output register, read pointer, oldest-bank pointer and header sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oldest    <= 1'b0;
      rd_ptr    <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
      m_cnt_o   <= '0;
`ifdef AIDC_LITE_DRAIN_HDR_EN
      seq       <= '0;
`endif
    end else begin
      oldest <= nxt_bank;
      if (start) begin
        m_valid_o <= 1'b1;
        m_cnt_o   <= start_cnt;
        rd_ptr    <= '0;
`ifdef AIDC_LITE_DRAIN_HDR_EN
        m_data_o  <= make_hdr(seq, start_cnt);
        m_last_o  <= 1'b0;
        seq       <= seq + 8'd1;
`else
        m_data_o  <= bank_rd[nxt_bank];
        m_last_o  <= (start_cnt == CW'(1));
`endif
      end else if (blk_done) begin
        m_valid_o <= 1'b0;
      end else if (beat) begin
        m_data_o <= bank_rd[oldest];
        if (hdr_beat) begin
          m_last_o <= (m_cnt_o == CW'(1));
        end else begin
          rd_ptr   <= rd_ptr + AW'(1);
          m_last_o <= ((CW'(rd_ptr) + CW'(2)) == m_cnt_o);
        end
      end
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overrun_o <= 1'b0;
    else if (ovr_set) overrun_o <= 1'b1;
  end

  assign busy_o = (bank_st[0] == BANK_CLOSED) | (bank_st[0] == BANK_DRAIN) |
                  (bank_st[1] == BANK_CLOSED) | (bank_st[1] == BANK_DRAIN);

endmodule
